// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and defaults for the serializer and sequence detector
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int   DEFAULT_DATA_W   = 8;
    localparam logic IDLE_BIT_DEFAULT = 1'b0;

endpackage

// File: rtl/seq_shift_reg.sv
// rtl/seq_shift_reg.sv - loadable shift register presenting its current outgoing bit
module seq_shift_reg #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift,
    output logic              bit_out
);

    logic [DATA_W-1:0] data;

    // Load wins over shift so a fresh word starts from its first bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift) begin
            if (MSB_FIRST)
                data <= {data[DATA_W-2:0], 1'b0};
            else
                data <= {1'b0, data[DATA_W-1:1]};
        end
    end

    assign bit_out = MSB_FIRST ? data[DATA_W-1] : data[0];

endmodule

// File: rtl/seq_serializer.sv
// rtl/seq_serializer.sv - parallel-to-serial stage with one-word holding register
module seq_serializer
    import seq_pkg::*;
#(
    parameter int   DATA_W    = DEFAULT_DATA_W,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              ser_en,
    output logic              out,
    output logic              out_valid,
    output logic              out_first,
    output logic              busy
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] hold;
    logic              hold_full;

    logic              accept;
    logic              last_bit;
    logic              sr_load;
    logic              sr_shift;
    logic [DATA_W-1:0] sr_load_data;
    logic              cur_bit;

    assign din_ready = !hold_full;
    assign accept    = din_valid && din_ready;
    assign last_bit  = (state == SHIFT) && ser_en && (bit_cnt == LAST_CNT);

    // A held word always takes priority; din only loads directly when hold is empty.
    always_comb begin
        sr_load      = 1'b0;
        sr_load_data = din;
        sr_shift     = 1'b0;
        if (state == IDLE) begin
            sr_load = accept;
        end else if (last_bit) begin
            sr_load      = hold_full || accept;
            sr_load_data = hold_full ? hold : din;
        end else begin
            sr_shift = ser_en;
        end
    end

    seq_shift_reg #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .reset     (reset),
        .load      (sr_load),
        .load_data (sr_load_data),
        .shift     (sr_shift),
        .bit_out   (cur_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        bit_cnt <= '0;
                        if (hold_full)
                            hold_full <= 1'b0;
                        else if (!accept)
                            state <= IDLE;
                    end else begin
                        if (ser_en)
                            bit_cnt <= bit_cnt + 1'b1;
                        if (accept) begin
                            hold      <= din;
                            hold_full <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out       = (state == SHIFT) ? cur_bit : IDLE_BIT;
    assign out_valid = (state == SHIFT);
    assign out_first = (state == SHIFT) && (bit_cnt == '0);
    assign busy      = (state == SHIFT) || hold_full;

endmodule

// File: tb/tb_seq_serializer.sv
// tb/tb_seq_serializer.sv - directed self-checking bench for seq_serializer
module tb_seq_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       ser_en = 1'b0;
    logic       din_ready, out, out_valid, out_first, busy;

    logic [7:0] l_din = '0;
    logic       l_din_valid = 1'b0;
    logic       l_ser_en = 1'b0;
    logic       l_din_ready, l_out, l_out_valid, l_out_first, l_busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .ser_en(ser_en), .out(out),
        .out_valid(out_valid), .out_first(out_first), .busy(busy)
    );

    seq_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .din(l_din), .din_valid(l_din_valid),
        .din_ready(l_din_ready), .ser_en(l_ser_en), .out(l_out),
        .out_valid(l_out_valid), .out_first(l_out_first), .busy(l_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        vectors++;
        if ({out, out_valid, out_first, busy, din_ready} !== 5'b00001) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 00001", {out, out_valid, out_first, busy, din_ready});
        end
        reset = 1'b1;
        step();
        vectors++;
        if ({out, out_valid, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_release_idle: got %b want 000", {out, out_valid, busy});
        end
    endtask

    task automatic test_single_word();
        logic [7:0] w;
        w = 8'hF8;
        din = w; din_valid = 1'b1; ser_en = 1'b1;
        step();
        din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if ({out, out_valid, out_first} !== {w[7-i], 1'b1, (i == 0)}) begin
                miscompares++;
                $display("FAIL single_bit%0d: got out/valid/first %b want %b", i,
                         {out, out_valid, out_first}, {w[7-i], 1'b1, (i == 0)});
            end
            step();
        end
        vectors++;
        if ({out, out_valid, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL single_idle_after: got %b want 000", {out, out_valid, busy});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s;
        s = {8'h0F, 8'hC0};
        din = 8'h0F; din_valid = 1'b1; ser_en = 1'b1;
        step();
        din = 8'hC0;
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if ({out, out_valid, out_first, din_ready} !==
                {s[15-i], 1'b1, (i == 0 || i == 8), !(i >= 1 && i <= 7)}) begin
                miscompares++;
                $display("FAIL b2b_bit%0d: got out/valid/first/ready %b want %b", i,
                         {out, out_valid, out_first, din_ready},
                         {s[15-i], 1'b1, (i == 0 || i == 8), !(i >= 1 && i <= 7)});
            end
            step();
            din_valid = 1'b0;
        end
        vectors++;
        if ({out_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_idle_after: got %b want 00", {out_valid, busy});
        end
    endtask

    task automatic test_stall();
        logic [7:0] w;
        w = 8'hA5;
        din = w; din_valid = 1'b1; ser_en = 1'b1;
        step();
        din_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            ser_en = (c % 2 == 1);
            vectors++;
            if ({out, out_valid, out_first} !== {w[7-c/2], 1'b1, (c < 2)}) begin
                miscompares++;
                $display("FAIL stall_cycle%0d: got %b want %b", c,
                         {out, out_valid, out_first}, {w[7-c/2], 1'b1, (c < 2)});
            end
            step();
        end
        ser_en = 1'b1;
        vectors++;
        if ({out_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL stall_idle_after: got %b want 00", {out_valid, busy});
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] w;
        w = 8'h01;
        l_din = w; l_din_valid = 1'b1; l_ser_en = 1'b1;
        step();
        l_din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if ({l_out, l_out_valid, l_out_first} !== {w[i], 1'b1, (i == 0)}) begin
                miscompares++;
                $display("FAIL lsb_bit%0d: got %b want %b", i,
                         {l_out, l_out_valid, l_out_first}, {w[i], 1'b1, (i == 0)});
            end
            step();
        end
        vectors++;
        if ({l_out, l_out_valid, l_busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL lsb_idle_after: got %b want 000", {l_out, l_out_valid, l_busy});
        end
    endtask

    task automatic test_reset_mid_word();
        din = 8'hFF; din_valid = 1'b1; ser_en = 1'b1;
        step();
        step();
        din_valid = 1'b0;
        step();
        step();
        vectors++;
        if ({out, out_valid, busy, din_ready} !== 4'b1110) begin
            miscompares++;
            $display("FAIL midrst_pre: got out/valid/busy/ready %b want 1110",
                     {out, out_valid, busy, din_ready});
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({out, out_valid, out_first, busy, din_ready} !== 5'b00001) begin
            miscompares++;
            $display("FAIL midrst_async: got %b want 00001", {out, out_valid, out_first, busy, din_ready});
        end
        step();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if ({out, out_valid, busy} !== 3'b000) begin
                miscompares++;
                $display("FAIL midrst_after%0d: got %b want 000", i, {out, out_valid, busy});
            end
        end
    endtask

    task automatic test_same_edge_accept();
        logic [15:0] s;
        s = {8'h01, 8'h80};
        din = 8'h01; din_valid = 1'b1; ser_en = 1'b1;
        step();
        din_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 7) begin
                din = 8'h80;
                din_valid = 1'b1;
            end
            vectors++;
            if ({out, out_valid, out_first, busy} !== {s[15-i], 1'b1, (i == 0 || i == 8), 1'b1}) begin
                miscompares++;
                $display("FAIL same_edge_bit%0d: got %b want %b", i,
                         {out, out_valid, out_first, busy}, {s[15-i], 1'b1, (i == 0 || i == 8), 1'b1});
            end
            step();
            din_valid = 1'b0;
        end
        vectors++;
        if ({out, out_valid, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL same_edge_idle_after: got %b want 000", {out, out_valid, busy});
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_lsb_first();
        test_reset_mid_word();
        test_same_edge_accept();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Parallel-to-serial stage directly upstream of the Moore sequence detector.
- Accepts DATA_W-bit words over a valid/ready handshake and emits them one bit per enabled clock on `out`, which drives the detector's `in`.
- A one-word holding register allows back-to-back words with no idle bit between them, so bit runs can span word boundaries for the detector's overlapping detection.

Parameters:
- DATA_W, 8, word width in bits; must be 2 or more.
- MSB_FIRST, 1, 1 = bit DATA_W-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0, value driven on `out` when no word is being sent. The default 0 clears the downstream detector's run.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- din  input  DATA_W  parallel word.
- din_valid  input  1  din is valid.
- din_ready  output  1  block can accept din this cycle.
- ser_en  input  1  bit-rate enable; the current bit is consumed on a rising edge where ser_en = 1.
- out  output  1  serial bit to the detector.
- out_valid  output  1  out carries a data bit (not the idle fill).
- out_first  output  1  out is the first bit of a word.
- busy  output  1  a word is being sent or the holding register is occupied.

Behaviour:
- Reset (reset = 0, takes effect asynchronously): state = IDLE, hold empty, bit_cnt = 0, out = IDLE_BIT, out_valid = 0, out_first = 0, busy = 0, din_ready = 1.
- Reset mid-word: the partial word and any held word are discarded. No bits are emitted after reset is released until a new word is accepted.
- Handshake:
  - A word is accepted on a rising edge where din_valid && din_ready.
  - din_ready = !hold_full. It is combinational from registered state only, with no path from din_valid.
  - din and din_valid may change freely when there is no transfer.
- FSM, 2 states:
  - IDLE:
    - hold is always empty.
    - On accept: load the word into the shift register, bit_cnt = 0, go to SHIFT.
    - Latency: the first bit appears on `out` in the cycle after the accepting edge, with out_valid = 1 and out_first = 1.
  - SHIFT:
    - out = current bit; out_valid = 1; out_first = (bit_cnt == 0).
    - On an edge with ser_en = 1: advance one bit, bit_cnt = bit_cnt + 1.
    - On an edge with ser_en = 0: hold out, bit_cnt and the shift register unchanged (stall).
    - An accept while in SHIFT writes the word into hold, and hold becomes full.
  - Last bit consumed (bit_cnt == DATA_W-1 and ser_en = 1):
    - If hold is full: move hold to the shift register, hold becomes empty, bit_cnt = 0, stay in SHIFT. There is no gap bit.
    - Else, if an accept happens on the same edge: load din directly into the shift register and stay in SHIFT. There is no gap.
    - Else: go to IDLE; out = IDLE_BIT from the next cycle.
  - Simultaneous last-bit consumption and accept while hold is full cannot occur, because din_ready = 0.
- bit_cnt width is $clog2(DATA_W). It counts 0..DATA_W-1 and never wraps past DATA_W-1 within a word.
- busy = (state == SHIFT) || hold_full.
- Bit ordering applies identically to words taken from din and from hold.

Decomposition:
- Shared package seq_pkg:
  - state typedef: IDLE = 1'b0, SHIFT = 1'b1.
  - default DATA_W constant.
  - IDLE_BIT default constant, reused by the detector's bench.
- One sub-module, seq_shift_reg: loadable DATA_W shift register with shift enable and a direction parameter; outputs the current bit.
- Holding register, handshake logic and FSM stay in seq_serializer.

Test Plan:
- Reset, then din = 8'hF8 accepted with ser_en held at 1 -> after the accept edge, out = 1,1,1,1,1,0,0,0 on consecutive cycles, out_first = 1 only on the first bit, then out = 0 with out_valid = 0; the downstream detector's out rises once.
- Two words 8'h0F then 8'hC0 offered back-to-back, ser_en = 1 -> hold fills and din_ready = 0 for 7 cycles; out = 00001111 followed immediately by 11000000, no gap; the detector sees a run of 6 ones across the boundary.
- ser_en toggled 1,0,1,0 during word 8'hA5 -> each bit held for 2 cycles; bit_cnt advances only on ser_en = 1 edges; 16 cycles total.
- MSB_FIRST = 0, din = 8'h01 -> out = 1,0,0,0,0,0,0,0.
- reset driven to 0 asynchronously mid-clock at bit 3 of 8'hFF with hold full -> out = IDLE_BIT and out_valid = 0 immediately; busy = 0 and din_ready = 1; after release, out stays idle until a new accept.
- Accept on the same edge as the last bit with hold empty (din = 8'h80 after 8'h01) -> bits 00000001 then 10000000 contiguous, out_first high at cycle 8.
